// File: rtl/vend_credit_sequencer.sv
// Coin-credit vending controller: accumulates credit, vends at PRICE and returns
// change one rupee at a time over request/ack handshakes, with a motor timeout fault.
module vend_credit_sequencer #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 9,
  parameter int VEND_TMO   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                buy,
  input  logic                cancel,
  output logic                vend_req,
  input  logic                vend_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                busy,
  output logic                fault
);

  localparam int TMO_W = $clog2(VEND_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE,
    S_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                vend_req_q, vend_req_d;
  logic                chg_req_q, chg_req_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;

  logic                accepting;
  logic                do_cancel;
  logic                do_coin;
  logic                coin_val_ok;
  logic                coin_fits;
  logic                coin_accept;
  logic                do_buy;
  logic                vend_done;
  logic                vend_tmo;
  logic                chg_done;
  logic [CREDIT_W:0]   coin_sum;
  logic [TMO_W-1:0]    tmo_next;

  // Event decode; cancel outranks coin, coin outranks buy, losers are dropped.
  assign accepting   = (state_q == S_IDLE) || (state_q == S_CREDIT);
  assign do_cancel   = (state_q == S_CREDIT) && cancel;
  assign do_coin     = accepting && coin_valid && !do_cancel;
  assign coin_val_ok = (coin_val == 2'd1) || (coin_val == 2'd2);
  assign coin_sum    = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_val};
  assign coin_fits   = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign coin_accept = do_coin && coin_val_ok && coin_fits;
  assign do_buy      = (state_q == S_CREDIT) && buy && !cancel && !coin_valid &&
                       (credit_q >= CREDIT_W'(PRICE));
  assign vend_done   = (state_q == S_VEND) && vend_ack;
  // vend_req is held for VEND_TMO cycles; an ack on the last of them still wins.
  assign tmo_next    = tmo_cnt_q + TMO_W'(1);
  assign vend_tmo    = (state_q == S_VEND) && !vend_ack && (tmo_next == TMO_W'(VEND_TMO));
  assign chg_done    = (state_q == S_CHANGE) && chg_req_q && chg_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      tmo_cnt_q     <= '0;
      vend_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      tmo_cnt_q     <= tmo_cnt_d;
      vend_req_q    <= vend_req_d;
      chg_req_q     <= chg_req_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (coin_accept) state_d = S_CREDIT;
      end
      S_CREDIT: begin
        if (do_cancel)   state_d = S_CHANGE;
        else if (do_buy) state_d = S_VEND;
      end
      S_VEND: begin
        if (vend_done)     state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
        else if (vend_tmo) state_d = S_CHANGE;
      end
      S_CHANGE: begin
        if ((chg_done && credit_q <= CREDIT_W'(1)) || credit_q == '0)
          state_d = fault_q ? S_FAULT : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (coin_accept)                       credit_d = coin_sum[CREDIT_W-1:0];
    else if (do_buy)                       credit_d = credit_q - CREDIT_W'(PRICE);
    else if (vend_tmo)                     credit_d = credit_q + CREDIT_W'(PRICE);
    else if (chg_done && credit_q != '0)   credit_d = credit_q - CREDIT_W'(1);
    else if (state_q == S_FAULT)           credit_d = '0;

    tmo_cnt_d     = (state_q == S_VEND) ? tmo_next : '0;
    vend_req_d    = do_buy || ((state_q == S_VEND) && !vend_ack && !vend_tmo);
    coin_reject_d = (do_coin && !coin_accept) || (!accepting && coin_valid);
    fault_d       = fault_q || vend_tmo;

    chg_req_d = 1'b0;
    if (do_cancel || vend_tmo || (vend_done && credit_q != '0))
      chg_req_d = 1'b1;
    else if (state_q == S_CHANGE)
      chg_req_d = chg_req_q ? !chg_ack : (credit_q != '0);

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE) || (state_d == S_FAULT);
  end

  assign vend_req    = vend_req_q;
  assign chg_req     = chg_req_q;
  assign credit      = credit_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_vend_credit_sequencer.sv
// Bench for vend_credit_sequencer: a vector table, directed corner-case sequences
// and a randomized run compared against a behavioural credit model.
module tb_vend_credit_sequencer;

  localparam int PRICE      = 3;
  localparam int MAX_CREDIT = 9;
  localparam int VEND_TMO   = 15;

  localparam int READY     = 0;
  localparam int VENDING   = 1;
  localparam int RETURNING = 2;
  localparam int HALTED    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = 2'd0;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       vend_req;
  logic       chg_req;
  logic [3:0] credit;
  logic       coin_reject;
  logic       busy;
  logic       fault;

  vend_credit_sequencer #(
    .CREDIT_W(4), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .VEND_TMO(VEND_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_val(coin_val),
    .buy(buy), .cancel(cancel), .vend_req(vend_req), .vend_ack(vend_ack),
    .chg_req(chg_req), .chg_ack(chg_ack), .credit(credit),
    .coin_reject(coin_reject), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: idle and credit are one phase, told apart by the credit value.
  int mCredit, mPhase, mVendAge;
  bit mVendOut, mChgOut, mRejOut, mFault;

  task automatic modelReset();
    mCredit = 0; mPhase = READY; mVendAge = 0;
    mVendOut = 0; mChgOut = 0; mRejOut = 0; mFault = 0;
  endtask

  task automatic modelStep(input bit cv, input int val, input bit b, input bit c,
                           input bit va, input bit ca);
    mRejOut = 0;
    case (mPhase)
      READY: begin
        if (c && mCredit > 0) begin
          mPhase = RETURNING; mChgOut = 1;
        end else if (cv) begin
          if ((val == 1 || val == 2) && mCredit + val <= MAX_CREDIT) mCredit += val;
          else mRejOut = 1;
        end else if (b && mCredit >= PRICE) begin
          mCredit -= PRICE; mPhase = VENDING; mVendOut = 1; mVendAge = 0;
        end
      end
      VENDING: begin
        mRejOut = cv;
        if (va) begin
          mVendOut = 0;
          if (mCredit > 0) begin mPhase = RETURNING; mChgOut = 1; end
          else mPhase = READY;
        end else begin
          mVendAge++;
          if (mVendAge == VEND_TMO) begin
            mVendOut = 0; mCredit += PRICE; mFault = 1; mPhase = RETURNING; mChgOut = 1;
          end
        end
      end
      RETURNING: begin
        mRejOut = cv;
        if (mChgOut && ca) begin
          mCredit--; mChgOut = 0;
          if (mCredit == 0) mPhase = mFault ? HALTED : READY;
        end else if (!mChgOut) begin
          mChgOut = 1;
        end
      end
      default: mRejOut = cv;
    endcase
  endtask

  function automatic logic [8:0] modelOut();
    return {4'(mCredit), mVendOut, mChgOut, mRejOut, (mPhase != READY), mFault};
  endfunction

  function automatic logic [8:0] pack(int cr, bit v, bit ch, bit rj, bit bz, bit f);
    return {4'(cr), v, ch, rj, bz, f};
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] expected);
    logic [8:0] actual;
    actual = {credit, vend_req, chg_req, coin_reject, busy, fault};
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got credit=%0d vend=%b chg=%b rej=%b busy=%b fault=%b, want credit=%0d vend=%b chg=%b rej=%b busy=%b fault=%b",
               name, $time, actual[8:5], actual[4], actual[3], actual[2], actual[1], actual[0],
               expected[8:5], expected[4], expected[3], expected[2], expected[1], expected[0]);
    end
  endtask

  task automatic applyStimulus(input bit cv, input logic [1:0] val, input bit b, input bit c,
                               input bit va, input bit ca);
    coin_valid = cv; coin_val = val; buy = b; cancel = c; vend_ack = va; chg_ack = ca;
    @(posedge clk);
    modelStep(cv, int'(val), b, c, va, ca);
    #1;
    coin_valid = 0; coin_val = 2'd0; buy = 0; cancel = 0; vend_ack = 0; chg_ack = 0;
  endtask

  task automatic idleCycle(input string name);
    applyStimulus(0, 2'd0, 0, 0, 0, 0);
    checkOutput(name, modelOut());
  endtask

  task automatic resetDut();
    coin_valid = 0; coin_val = 2'd0; buy = 0; cancel = 0; vend_ack = 0; chg_ack = 0;
    #2 rst_n = 0;
    #1;
    modelReset();
    checkOutput("reset_async", pack(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  // Return n change coins: ack while chg_req is high, then an ignored ack in the gap.
  task automatic drainChange(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 2'd0, 0, 0, 0, 1);
      checkOutput("change_ack", modelOut());
      if (k < n - 1) begin
        applyStimulus(0, 2'd0, 0, 0, 0, 1);
        checkOutput("change_gap", modelOut());
      end
    end
  endtask

  typedef struct {
    bit       cv;
    bit [1:0] val;
    bit       b, c, va, ca;
    int       eCredit;
    bit       eVend, eChg, eRej, eBusy, eFault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit cv, bit [1:0] val, bit b, bit c, bit va, bit ca,
                              int cr, bit v, bit ch, bit rj, bit bz, bit f);
    vec_t r;
    r.cv = cv; r.val = val; r.b = b; r.c = c; r.va = va; r.ca = ca;
    r.eCredit = cr; r.eVend = v; r.eChg = ch; r.eRej = rj; r.eBusy = bz; r.eFault = f;
    return r;
  endfunction

  initial begin
    // coins 2,2, buy, ack three cycles later, one change coin
    vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 0, 0, 0,  1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 1, 0,  1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // coins 1,1, buy ignored, cancel returns two coins
    vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 0, 0, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 0, 1, 0, 0,  2, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0,  2, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // fill to 8, overflow and invalid coins, fill to the 9 cap, vend with coin rejected
    vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0,  8, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0,  8, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 0,  8, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 0, 0,  8, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0,  9, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0,  9, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 0, 0, 0,  6, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0,  6, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 2'd0, 1, 1, 0, 0,  6, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 1, 0,  6, 0, 1, 0, 1, 0));

    modelReset();
    resetDut();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].cv, vecs[i].val, vecs[i].b, vecs[i].c, vecs[i].va, vecs[i].ca);
      checkOutput($sformatf("vector_%0d", i),
                  pack(vecs[i].eCredit, vecs[i].eVend, vecs[i].eChg, vecs[i].eRej,
                       vecs[i].eBusy, vecs[i].eFault));
    end
    drainChange(6);
    checkOutput("drain6_idle", pack(0, 0, 0, 0, 0, 0));

    // Motor timeout: refund, three change coins, then terminal fault
    resetDut();
    applyStimulus(1, 2'd2, 0, 0, 0, 0);
    applyStimulus(1, 2'd1, 0, 0, 0, 0);
    applyStimulus(0, 2'd0, 1, 0, 0, 0);
    checkOutput("tmo_vend_start", pack(0, 1, 0, 0, 1, 0));
    for (int k = 1; k < VEND_TMO; k++) idleCycle("tmo_waiting");
    checkOutput("tmo_last_wait", pack(0, 1, 0, 0, 1, 0));
    idleCycle("tmo_expire");
    checkOutput("tmo_refund", pack(3, 0, 1, 0, 1, 1));
    drainChange(3);
    checkOutput("fault_entered", pack(0, 0, 0, 0, 1, 1));
    applyStimulus(1, 2'd1, 0, 0, 0, 0);
    checkOutput("fault_coin_rej", pack(0, 0, 0, 1, 1, 1));
    applyStimulus(0, 2'd0, 1, 1, 1, 1);
    checkOutput("fault_ignores", pack(0, 0, 0, 0, 1, 1));

    // Ack landing on the timeout cycle wins
    resetDut();
    applyStimulus(1, 2'd2, 0, 0, 0, 0);
    applyStimulus(1, 2'd1, 0, 0, 0, 0);
    applyStimulus(0, 2'd0, 1, 0, 0, 0);
    for (int k = 1; k < VEND_TMO; k++) idleCycle("race_waiting");
    applyStimulus(0, 2'd0, 0, 0, 1, 0);
    checkOutput("race_ack_wins", pack(0, 0, 0, 0, 0, 0));

    // Same-cycle priority, then reset in the middle of change return
    resetDut();
    applyStimulus(1, 2'd2, 0, 0, 0, 0);
    applyStimulus(1, 2'd1, 0, 0, 0, 0);
    applyStimulus(1, 2'd1, 1, 0, 0, 0);
    checkOutput("coin_beats_buy", pack(4, 0, 0, 0, 0, 0));
    applyStimulus(1, 2'd1, 0, 1, 0, 0);
    checkOutput("cancel_beats_coin", pack(4, 0, 1, 0, 1, 0));
    drainChange(2);
    checkOutput("mid_change", pack(2, 0, 0, 0, 1, 0));
    resetDut();
    idleCycle("after_reset_idle");
    applyStimulus(1, 2'd1, 0, 0, 0, 0);
    checkOutput("after_reset_coin", pack(1, 0, 0, 0, 0, 0));

    // Randomized run against the model
    resetDut();
    for (int i = 0; i < 3000; i++) begin
      bit cv, b, c, va, ca;
      logic [1:0] val;
      if (i % 300 == 299) resetDut();
      cv  = ($urandom_range(3) == 0);
      val = 2'($urandom_range(3));
      b   = ($urandom_range(3) == 0);
      c   = ($urandom_range(9) == 0);
      va  = ($urandom_range(9) == 0);
      ca  = ($urandom_range(1) == 0);
      if (mPhase == READY && mCredit == 0 && c) cv = 0;
      applyStimulus(cv, val, b, c, va, ca);
      checkOutput("random", modelOut());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
